// File: rtl/mr1_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mr1_mem_arbiter
// Brief    : Shares one memory port between MR1 fetch and data channels and
//            steers in-order read responses back through a tag FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module mr1_mem_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int DATA_PRIO       = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instr_req_valid,
    output logic        instr_req_ready,
    input  logic [31:0] instr_req_addr,
    output logic        instr_rsp_valid,
    output logic [31:0] instr_rsp_data,
    input  logic        data_req_valid,
    output logic        data_req_ready,
    input  logic        data_req_wr,
    input  logic [1:0]  data_req_size,
    input  logic [31:0] data_req_addr,
    input  logic [31:0] data_req_data,
    output logic        data_rsp_valid,
    output logic [31:0] data_rsp_data,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_wr,
    output logic [1:0]  mem_req_size,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_data,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        rsp_err
);

    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_MAX_CNT = CW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD_I = 2'd1,
        S_HOLD_D = 2'd2
    } state_t;

    state_t                   r_state;
    logic                     r_prefer_data;
    logic [MAX_OUTSTANDING-1:0] r_tags;
    logic [PW-1:0]            r_wr_ptr;
    logic [PW-1:0]            r_rd_ptr;
    logic [CW-1:0]            r_count;
    logic                     r_rsp_err;

    logic w_elig_i;
    logic w_elig_d;
    logic w_gnt_i;
    logic w_gnt_d;
    logic w_xfer;
    logic w_push;
    logic w_pop;
    logic w_head_tag;

    // Eligibility looks only at the registered count: a pop in the same
    // cycle never frees a slot for a read being granted now.
    always_comb begin
        w_elig_i = instr_req_valid && (r_count < C_MAX_CNT);
        w_elig_d = data_req_valid && (data_req_wr || (r_count < C_MAX_CNT));
        w_gnt_i  = 1'b0;
        w_gnt_d  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_elig_i && w_elig_d) begin
                    if ((DATA_PRIO != 0) || r_prefer_data) begin
                        w_gnt_d = 1'b1;
                    end else begin
                        w_gnt_i = 1'b1;
                    end
                end else begin
                    w_gnt_i = w_elig_i;
                    w_gnt_d = w_elig_d;
                end
            end
            S_HOLD_I: w_gnt_i = 1'b1;
            S_HOLD_D: w_gnt_d = 1'b1;
            default: ;
        endcase
        if (!reset_n) begin
            w_gnt_i = 1'b0;
            w_gnt_d = 1'b0;
        end
    end

    always_comb begin
        mem_req_valid = w_gnt_i | w_gnt_d;
        mem_req_wr    = 1'b0;
        mem_req_size  = 2'd0;
        mem_req_addr  = 32'd0;
        mem_req_data  = 32'd0;
        if (w_gnt_d) begin
            mem_req_wr   = data_req_wr;
            mem_req_size = data_req_size;
            mem_req_addr = data_req_addr;
            mem_req_data = data_req_data;
        end else if (w_gnt_i) begin
            mem_req_size = 2'd2;
            mem_req_addr = instr_req_addr;
        end
    end

    assign w_xfer          = mem_req_valid && mem_req_ready;
    assign instr_req_ready = w_xfer && w_gnt_i;
    assign data_req_ready  = w_xfer && w_gnt_d;
    assign w_push          = w_xfer && (w_gnt_i || !data_req_wr);
    assign w_pop           = reset_n && mem_rsp_valid && (r_count != '0);
    assign w_head_tag      = r_tags[r_rd_ptr];

    assign instr_rsp_valid = w_pop && !w_head_tag;
    assign data_rsp_valid  = w_pop && w_head_tag;
    assign instr_rsp_data  = instr_rsp_valid ? mem_rsp_data : 32'd0;
    assign data_rsp_data   = data_rsp_valid ? mem_rsp_data : 32'd0;
    assign rsp_err         = r_rsp_err;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_prefer_data <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mem_req_valid && !mem_req_ready) begin
                        r_state <= w_gnt_d ? S_HOLD_D : S_HOLD_I;
                    end
                end
                S_HOLD_I, S_HOLD_D: begin
                    if (mem_req_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // The channel just served loses the next tie.
            if (w_xfer) begin
                r_prefer_data <= w_gnt_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tags    <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_tags[r_wr_ptr] <= w_gnt_d;
                r_wr_ptr         <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
            if (mem_rsp_valid && (r_count == '0)) begin
                r_rsp_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mr1_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mr1_mem_arbiter
// Brief    : Directed bench for mr1_mem_arbiter, fixed-priority and
//            round-robin instances driven from shared inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mr1_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        instr_req_valid;
    logic [31:0] instr_req_addr;
    logic        data_req_valid;
    logic        data_req_wr;
    logic [1:0]  data_req_size;
    logic [31:0] data_req_addr;
    logic [31:0] data_req_data;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    logic        a_instr_req_ready, a_instr_rsp_valid, a_data_req_ready, a_data_rsp_valid;
    logic [31:0] a_instr_rsp_data, a_data_rsp_data, a_mem_req_addr, a_mem_req_data;
    logic        a_mem_req_valid, a_mem_req_wr, a_rsp_err;
    logic [1:0]  a_mem_req_size;

    logic        b_instr_req_ready, b_instr_rsp_valid, b_data_req_ready, b_data_rsp_valid;
    logic [31:0] b_instr_rsp_data, b_data_rsp_data, b_mem_req_addr, b_mem_req_data;
    logic        b_mem_req_valid, b_mem_req_wr, b_rsp_err;
    logic [1:0]  b_mem_req_size;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mr1_mem_arbiter #(.MAX_OUTSTANDING(4), .DATA_PRIO(1)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .instr_req_valid(instr_req_valid), .instr_req_ready(a_instr_req_ready),
        .instr_req_addr(instr_req_addr),
        .instr_rsp_valid(a_instr_rsp_valid), .instr_rsp_data(a_instr_rsp_data),
        .data_req_valid(data_req_valid), .data_req_ready(a_data_req_ready),
        .data_req_wr(data_req_wr), .data_req_size(data_req_size),
        .data_req_addr(data_req_addr), .data_req_data(data_req_data),
        .data_rsp_valid(a_data_rsp_valid), .data_rsp_data(a_data_rsp_data),
        .mem_req_valid(a_mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_wr(a_mem_req_wr), .mem_req_size(a_mem_req_size),
        .mem_req_addr(a_mem_req_addr), .mem_req_data(a_mem_req_data),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .rsp_err(a_rsp_err)
    );

    mr1_mem_arbiter #(.MAX_OUTSTANDING(4), .DATA_PRIO(0)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .instr_req_valid(instr_req_valid), .instr_req_ready(b_instr_req_ready),
        .instr_req_addr(instr_req_addr),
        .instr_rsp_valid(b_instr_rsp_valid), .instr_rsp_data(b_instr_rsp_data),
        .data_req_valid(data_req_valid), .data_req_ready(b_data_req_ready),
        .data_req_wr(data_req_wr), .data_req_size(data_req_size),
        .data_req_addr(data_req_addr), .data_req_data(data_req_data),
        .data_rsp_valid(b_data_rsp_valid), .data_rsp_data(b_data_rsp_data),
        .mem_req_valid(b_mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_wr(b_mem_req_wr), .mem_req_size(b_mem_req_size),
        .mem_req_addr(b_mem_req_addr), .mem_req_data(b_mem_req_data),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .rsp_err(b_rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        instr_req_valid = 1'b0;
        instr_req_addr  = 32'd0;
        data_req_valid  = 1'b0;
        data_req_wr     = 1'b0;
        data_req_size   = 2'd0;
        data_req_addr   = 32'd0;
        data_req_data   = 32'd0;
        mem_req_ready   = 1'b0;
        mem_rsp_valid   = 1'b0;
        mem_rsp_data    = 32'd0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic load(input logic [31:0] addr);
        data_req_valid = 1'b1;
        data_req_wr    = 1'b0;
        data_req_size  = 2'd2;
        data_req_addr  = addr;
        data_req_data  = 32'd0;
    endtask

    initial begin
        clear_inputs();
        reset_n = 1'b0;
        tick();
        // Outputs must be gated while reset is asserted, even with live inputs.
        instr_req_valid = 1'b1;
        instr_req_addr  = 32'h0000_0100;
        load(32'h0000_0200);
        mem_req_ready   = 1'b1;
        mem_rsp_valid   = 1'b1;
        mem_rsp_data    = 32'h1234_5678;
        #1;
        chk("rst_mem_valid", {31'd0, a_mem_req_valid}, 32'd0);
        chk("rst_i_ready", {31'd0, a_instr_req_ready}, 32'd0);
        chk("rst_d_ready", {31'd0, a_data_req_ready}, 32'd0);
        chk("rst_i_rsp", {31'd0, a_instr_rsp_valid}, 32'd0);
        chk("rst_d_rsp_data", a_data_rsp_data, 32'd0);
        tick();
        do_reset();
        #1;
        chk("rst_err", {31'd0, a_rsp_err}, 32'd0);

        // T1: data wins under fixed priority, instr follows
        instr_req_valid = 1'b1;
        instr_req_addr  = 32'h0000_0100;
        load(32'h0000_0200);
        mem_req_ready   = 1'b1;
        #1;
        chk("t1_addr0", a_mem_req_addr, 32'h0000_0200);
        chk("t1_dready0", {31'd0, a_data_req_ready}, 32'd1);
        chk("t1_iready0", {31'd0, a_instr_req_ready}, 32'd0);
        tick();
        data_req_valid = 1'b0;
        #1;
        chk("t1_addr1", a_mem_req_addr, 32'h0000_0100);
        chk("t1_iready1", {31'd0, a_instr_req_ready}, 32'd1);
        chk("t1_size1", {30'd0, a_mem_req_size}, 32'd2);
        chk("t1_wr1", {31'd0, a_mem_req_wr}, 32'd0);
        tick();

        // T2: round-robin alternates I,D,I,D
        do_reset();
        instr_req_valid = 1'b1;
        instr_req_addr  = 32'h0000_0100;
        load(32'h0000_0200);
        mem_req_ready   = 1'b1;
        #1;
        chk("t2_g0_addr", b_mem_req_addr, 32'h0000_0100);
        chk("t2_g0_iready", {31'd0, b_instr_req_ready}, 32'd1);
        tick();
        chk("t2_g1_addr", b_mem_req_addr, 32'h0000_0200);
        chk("t2_g1_dready", {31'd0, b_data_req_ready}, 32'd1);
        tick();
        chk("t2_g2_addr", b_mem_req_addr, 32'h0000_0100);
        tick();
        chk("t2_g3_addr", b_mem_req_addr, 32'h0000_0200);
        tick();

        // T3: grant held on instr while memory stalls
        do_reset();
        instr_req_valid = 1'b1;
        instr_req_addr  = 32'h0000_0300;
        #1;
        chk("t3_c1_addr", a_mem_req_addr, 32'h0000_0300);
        chk("t3_c1_valid", {31'd0, a_mem_req_valid}, 32'd1);
        tick();
        load(32'h0000_0400);
        #1;
        chk("t3_c2_addr", a_mem_req_addr, 32'h0000_0300);
        chk("t3_c2_dready", {31'd0, a_data_req_ready}, 32'd0);
        tick();
        chk("t3_c3_addr", a_mem_req_addr, 32'h0000_0300);
        tick();
        mem_req_ready = 1'b1;
        #1;
        chk("t3_c4_addr", a_mem_req_addr, 32'h0000_0300);
        chk("t3_c4_iready", {31'd0, a_instr_req_ready}, 32'd1);
        chk("t3_c4_dready", {31'd0, a_data_req_ready}, 32'd0);
        tick();
        instr_req_valid = 1'b0;
        #1;
        chk("t3_c5_addr", a_mem_req_addr, 32'h0000_0400);
        chk("t3_c5_dready", {31'd0, a_data_req_ready}, 32'd1);
        tick();

        // T4: four loads fill the tag FIFO; stores still pass
        do_reset();
        mem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            load(32'h0000_0010 + 32'(i * 4));
            #1;
            chk("t4_load_ready", {31'd0, a_data_req_ready}, 32'd1);
            tick();
        end
        load(32'h0000_0020);
        #1;
        chk("t4_full_dready", {31'd0, a_data_req_ready}, 32'd0);
        chk("t4_full_valid", {31'd0, a_mem_req_valid}, 32'd0);
        data_req_wr   = 1'b1;
        data_req_addr = 32'h0000_0050;
        data_req_data = 32'hDEAD_BEEF;
        #1;
        chk("t4_st_dready", {31'd0, a_data_req_ready}, 32'd1);
        chk("t4_st_wr", {31'd0, a_mem_req_wr}, 32'd1);
        chk("t4_st_data", a_mem_req_data, 32'hDEAD_BEEF);
        tick();
        load(32'h0000_0020);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_0011;
        #1;
        chk("t4_pop_rsp", {31'd0, a_data_rsp_valid}, 32'd1);
        chk("t4_pop_data", a_data_rsp_data, 32'h0000_0011);
        chk("t4_pop_dready", {31'd0, a_data_req_ready}, 32'd0);
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'd0;
        #1;
        chk("t4_after_dready", {31'd0, a_data_req_ready}, 32'd1);
        tick();

        // T5: in-order responses routed by tag
        do_reset();
        mem_req_ready   = 1'b1;
        instr_req_valid = 1'b1;
        instr_req_addr  = 32'h0000_0100;
        tick();
        instr_req_valid = 1'b0;
        load(32'h0000_0200);
        tick();
        data_req_valid  = 1'b0;
        instr_req_valid = 1'b1;
        instr_req_addr  = 32'h0000_0104;
        tick();
        instr_req_valid = 1'b0;
        mem_rsp_valid   = 1'b1;
        mem_rsp_data    = 32'hAAAA_0001;
        #1;
        chk("t5_a_ivalid", {31'd0, a_instr_rsp_valid}, 32'd1);
        chk("t5_a_idata", a_instr_rsp_data, 32'hAAAA_0001);
        chk("t5_a_dvalid", {31'd0, a_data_rsp_valid}, 32'd0);
        chk("t5_a_ddata", a_data_rsp_data, 32'd0);
        tick();
        mem_rsp_data = 32'hBBBB_0002;
        #1;
        chk("t5_b_dvalid", {31'd0, a_data_rsp_valid}, 32'd1);
        chk("t5_b_ddata", a_data_rsp_data, 32'hBBBB_0002);
        chk("t5_b_ivalid", {31'd0, a_instr_rsp_valid}, 32'd0);
        tick();
        mem_rsp_data = 32'hCCCC_0003;
        #1;
        chk("t5_c_ivalid", {31'd0, a_instr_rsp_valid}, 32'd1);
        chk("t5_c_idata", a_instr_rsp_data, 32'hCCCC_0003);
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'd0;
        #1;
        chk("t5_err", {31'd0, a_rsp_err}, 32'd0);

        // T6: stray response sets sticky error; reset clears error and count
        do_reset();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h5555_5555;
        #1;
        chk("t6_no_irsp", {31'd0, a_instr_rsp_valid}, 32'd0);
        chk("t6_no_drsp", {31'd0, a_data_rsp_valid}, 32'd0);
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'd0;
        #1;
        chk("t6_err_set", {31'd0, a_rsp_err}, 32'd1);
        mem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            load(32'h0000_0600 + 32'(i * 4));
            tick();
        end
        #1;
        chk("t6_err_held", {31'd0, a_rsp_err}, 32'd1);
        chk("t6_full_dready", {31'd0, a_data_req_ready}, 32'd0);
        do_reset();
        mem_req_ready = 1'b1;
        load(32'h0000_0700);
        #1;
        chk("t6_err_clr", {31'd0, a_rsp_err}, 32'd0);
        chk("t6_cnt_clr", {31'd0, a_data_req_ready}, 32'd1);
        tick();
        clear_inputs();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
